// File: rtl/dma_job_arbiter_if.sv
// dma_job_arbiter_if: requester, engine and completion signals of the DMA job
// arbiter, bundled into one interface.
//   req_valid/req_ready   per-requester job handshake (ready is a one-hot grant)
//   req_sa/req_len        packed 32-bit start address / byte length per requester
//   cfg_dma_*             job handed to the burst-partition engine
//   cur_id, busy          index of the held job, arbiter-not-idle flag
//   done_valid/id/zero    one-cycle completion report
// Modports: master = arbiter side, slave = requesters + engine side.
interface dma_job_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*32-1:0] req_sa;
   logic [NREQ*32-1:0] req_len;
   logic               cfg_dma_valid;
   logic               cfg_dma_ready;
   logic [31:0]        cfg_dma_sa;
   logic [31:0]        cfg_dma_len;
   logic [IDW-1:0]     cur_id;
   logic               busy;
   logic               done_valid;
   logic [IDW-1:0]     done_id;
   logic               done_zero;

   modport master (
      input  req_valid, req_sa, req_len, cfg_dma_ready,
      output req_ready, cfg_dma_valid, cfg_dma_sa, cfg_dma_len,
             cur_id, busy, done_valid, done_id, done_zero
   );

   modport slave (
      output req_valid, req_sa, req_len, cfg_dma_ready,
      input  req_ready, cfg_dma_valid, cfg_dma_sa, cfg_dma_len,
             cur_id, busy, done_valid, done_id, done_zero
   );
endinterface

// File: rtl/dma_job_arbiter.sv
// dma_job_arbiter: round-robin scheduler sharing one burst-partition engine
// between NREQ DMA requesters. Grants one requester at a time, captures its
// start address/length, issues the job to the engine, waits for the engine to
// return idle and reports completion. Jobs shorter than one AXI word are
// retired locally without touching the engine.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (shared with the engine)
//   bus      dma_job_arbiter_if.master (requester handshake, engine job
//            interface, cur_id/busy status, done report)
// All outputs are registered except bus.req_ready.
module dma_job_arbiter #(
   parameter  int NREQ      = 4,
   parameter  int AXI_DW    = 128,
   localparam int AXI_BYTES = AXI_DW / 8,
   localparam int L         = $clog2(AXI_BYTES),
   localparam int IDW       = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                reset_n,
   dma_job_arbiter_if.master   bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t          state_q;
   logic [IDW-1:0]  rr_ptr_q;
   logic [IDW-1:0]  cur_id_q;
   logic [IDW-1:0]  done_id_q;
   logic [31:0]     sa_q;
   logic [31:0]     len_q;
   logic            cfg_valid_q;
   logic            busy_q;
   logic            done_valid_q;
   logic            done_zero_q;

   logic            win_any_d;
   logic [IDW-1:0]  win_idx_d;
   logic [31:0]     win_sa_d;
   logic [31:0]     win_len_d;
   logic [NREQ-1:0] win_onehot_d;
   logic            win_short_d;

   // Round-robin search: walk from rr_ptr+1 around the ring, first set bit wins.
   always_comb begin
      int unsigned idx;
      idx          = '0;
      win_any_d    = 1'b0;
      win_idx_d    = '0;
      win_sa_d     = '0;
      win_len_d    = '0;
      win_onehot_d = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = 32'(rr_ptr_q) + k;
         if (idx >= 32'(NREQ)) begin
            idx = idx - 32'(NREQ);
         end
         if (!win_any_d && bus.req_valid[idx]) begin
            win_any_d         = 1'b1;
            win_idx_d         = IDW'(idx);
            win_sa_d          = bus.req_sa[idx*32 +: 32];
            win_len_d         = bus.req_len[idx*32 +: 32];
            win_onehot_d[idx] = 1'b1;
         end
      end
   end

   // Less than one full AXI word (including zero) never reaches the engine.
   assign win_short_d = (win_len_d[31:L] == '0);

   // Grant is combinational in IDLE; gated by reset so it reads 0 while held.
   assign bus.req_ready = (state_q == S_IDLE && reset_n) ? win_onehot_d : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= IDW'(NREQ - 1);
         cur_id_q     <= '0;
         done_id_q    <= '0;
         sa_q         <= '0;
         len_q        <= '0;
         cfg_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_valid_q <= 1'b0;
         done_zero_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (win_any_d) begin
                  sa_q     <= win_sa_d;
                  len_q    <= win_len_d;
                  cur_id_q <= win_idx_d;
                  rr_ptr_q <= win_idx_d;
                  busy_q   <= 1'b1;
                  if (win_short_d) begin
                     state_q      <= S_DONE;
                     done_valid_q <= 1'b1;
                     done_zero_q  <= 1'b1;
                     done_id_q    <= win_idx_d;
                  end else begin
                     state_q     <= S_ISSUE;
                     cfg_valid_q <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (bus.cfg_dma_ready) begin
                  cfg_valid_q <= 1'b0;
                  state_q     <= S_WAIT;
               end
            end
            // Engine drops ready after acceptance; ready seen again here means
            // it has drained the job and is idle.
            S_WAIT: begin
               if (bus.cfg_dma_ready) begin
                  state_q      <= S_DONE;
                  done_valid_q <= 1'b1;
                  done_zero_q  <= 1'b0;
                  done_id_q    <= cur_id_q;
               end
            end
            S_DONE: begin
               done_valid_q <= 1'b0;
               done_zero_q  <= 1'b0;
               busy_q       <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.cfg_dma_valid = cfg_valid_q;
   assign bus.cfg_dma_sa    = sa_q;
   assign bus.cfg_dma_len   = len_q;
   assign bus.cur_id        = cur_id_q;
   assign bus.busy          = busy_q;
   assign bus.done_valid    = done_valid_q;
   assign bus.done_id       = done_id_q;
   assign bus.done_zero     = done_zero_q;

endmodule

// File: doc/dma_job_arbiter.md
# dma_job_arbiter

Round-robin job scheduler that shares a single burst-partition engine (the AW/AR burst splitter with `cfg_dma_valid/ready/sa/len`) between several DMA requesters. It grants one requester at a time, captures that requester's start address and length, and issues the job to the engine. It then waits for the engine to return to idle and reports completion with the requester's index. Jobs too short to form a single AXI word are retired locally and never reach the engine.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `AXI_DW`, 128: AXI data width; must match the partition engine.
- `AXI_BYTES`, `AXI_DW/8`: bytes per AXI word (derived).
- `L`, `$clog2(AXI_BYTES)`: word-offset bits (derived).
- `IDW`, `$clog2(NREQ)`: requester index width (derived).

- `clk` input 1: single clock; all logic on the rising edge.
- `reset_n` input 1: asynchronous active-low reset.
- `req_valid` input NREQ: per-requester job request.
- `req_ready` output NREQ: one-hot grant/accept, asserted for one cycle.
- `req_sa` input NREQ*32: start byte addresses; requester i occupies bits [32i+31:32i].
- `req_len` input NREQ*32: byte lengths, packed the same way.
- `cfg_dma_valid` output 1: job valid toward the partition engine.
- `cfg_dma_ready` input 1: engine idle/accept.
- `cfg_dma_sa` output 32: captured start address.
- `cfg_dma_len` output 32: captured length.
- `cur_id` output IDW: index of the job currently held.
- `busy` output 1: high in every state except IDLE.
- `done_valid` output 1: one-cycle completion pulse.
- `done_id` output IDW: index of the completed job.
- `done_zero` output 1: with `done_valid`, the job was retired without reaching the engine.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` is set, pick winner g by round-robin. Search starts at `rr_ptr+1` (mod NREQ) and takes the first set bit.
  - Drive `req_ready[g]=1` combinationally in the same cycle. `req_ready` is 0 in every other state.
  - On that edge, capture `req_sa[g]` into `cfg_dma_sa`, `req_len[g]` into `cfg_dma_len`, g into `cur_id`, and set `rr_ptr<=g`.
  - If `req_len[g][31:L]==0` (length shorter than one AXI word, including 0), go to DONE with `done_zero` set.
  - Otherwise go to ISSUE.
- **ISSUE**: `cfg_dma_valid=1`. Hold address, length and id stable until `cfg_dma_ready=1`, then go to WAIT.
- **WAIT**: `cfg_dma_valid=0`. The engine deasserts ready the cycle after acceptance. Any cycle in WAIT with `cfg_dma_ready=1` means the job has finished; go to DONE.
- **DONE**
  - `done_valid=1` for exactly one cycle.
  - `done_id=cur_id`. `done_zero` is 1 only for locally retired jobs.
  - Next state is IDLE.
- `rr_ptr` resets to NREQ-1, so requester 0 has top priority after reset.
- Requesters must hold `req_sa`/`req_len` stable while `req_valid` is high. A requester may deassert `req_valid` before it is granted; a request that is not granted is not captured.
- Address and length pass through unmodified; the engine applies word alignment.

## Timing
- Reset values:
  - `req_ready`, `cfg_dma_valid`, `busy`, `done_valid`, `done_zero`: 0.
  - `cfg_dma_sa`, `cfg_dma_len`: 0.
  - `cur_id`, `done_id`: 0.
- Grant to `cfg_dma_valid`: the grant cycle is T, and `cfg_dma_valid` rises at T+1.
- Minimum job turnaround: grant at T, engine accepts at T+1, WAIT from T+2. Completion is seen at the earliest in the engine's last-burst cycle +1; DONE follows, then IDLE. The next grant comes no earlier than one cycle after DONE.
- Zero-length job: grant at T, DONE at T+1 with `done_zero=1`, IDLE at T+2.
- `req_valid` arriving during a job: held pending, arbitrated in the first IDLE cycle.
- Reset asserted mid-job (ISSUE or WAIT): everything returns immediately to reset values, and no `done_valid` is produced for the aborted job. The engine shares the same `reset_n`.
- All outputs except `req_ready` are registered.

## Test plan
- Single job: `req_valid[2]`, sa=0x1000, len=0x400 → `req_ready[2]` for one cycle. Next cycle `cfg_dma_valid=1` with sa=0x1000, len=0x400, `cur_id=2`. After the engine completes, `done_valid` with `done_id=2`, `done_zero=0`.
- Fairness: all four `req_valid` held high, len=0x100 each → grant order 0,1,2,3,0,1, one `done_valid` per job in the same order.
- Zero/short length: `req_len=8` with AXI_BYTES=16 → `done_zero=1` one cycle after grant, and `cfg_dma_valid` never asserts.
- Engine backpressure: `cfg_dma_ready` held low for 10 cycles in ISSUE → `cfg_dma_valid`, sa, len and `cur_id` stay stable; transition to WAIT only on the ready cycle.
- Late arrival: `req_valid[3]` rises while job 1 is in WAIT → `req_ready[3]` appears in the first IDLE cycle after DONE(id=1).
- Reset in WAIT: pull `reset_n` low → all outputs 0, no `done_valid`. After release, `req_valid[1]` and `req_valid[0]` together → requester 0 is granted first.
